// File: rtl/puf_pkg.sv
// Shared definitions for the PUF response generator: FSM state type and
// default sizing constants.
package puf_pkg;

  // Default width of one oscillator count sample.
  localparam int PUF_CNT_BIT_SIZE = 5;
  // Default number of response bits (one per count pair) in a word.
  localparam int PUF_RESP_BITS    = 16;

  // S_CAP_A: waiting for first count of a pair
  // S_CAP_B: waiting for second count of a pair
  // S_HOLD : word complete, waiting for the consumer
  typedef enum logic [1:0] {
    S_CAP_A = 2'd0,
    S_CAP_B = 2'd1,
    S_HOLD  = 2'd2
  } puf_state_e;

endpackage

// File: rtl/puf_pair_cmp.sv
// Combinational unsigned compare of two oscillator counts over the full width.
module puf_pair_cmp #(
  parameter int W = 5
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic         gt_o,
  output logic         eq_o
);

  // Plain unsigned magnitude compare; a tie is reported separately.
  always_comb begin
    gt_o = (a_i > b_i);
    eq_o = (a_i == b_i);
  end

endmodule

// File: rtl/puf_resp_gen.sv
// PUF response generator: collects pairs of oscillator counts, turns each
// pair into one response bit (A > B), and presents the assembled word to a
// consumer with a valid/ready hold.
//
// Optional feature: define PUF_TIE_MASK_EN to add o_tie_mask, a per-pair flag
// marking pairs whose two counts were equal.
//
// Handshake: o_resp_valid rises the cycle after the last bit is written and
// stays high with o_resp frozen until i_resp_ready is sampled high on a clock
// edge; that edge is the transfer and the word is cleared on it. i_valid is a
// one-cycle strobe with no back-pressure: strobes arriving while a word is
// held are dropped and recorded in the sticky o_overrun flag.
//
// o_state and o_pair_idx are debug views of the FSM state and pair index.
module puf_resp_gen
  import puf_pkg::*;
#(
  parameter int  CNT_BIT_SIZE = PUF_CNT_BIT_SIZE,
  parameter int  RESP_BITS    = PUF_RESP_BITS,
  localparam int IDX_W        = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_en,
  input  logic                    i_valid,
  input  logic [CNT_BIT_SIZE-1:0] i_count,
  input  logic                    i_resp_ready,
  output logic [RESP_BITS-1:0]    o_resp,
  output logic                    o_resp_valid,
  output logic                    o_busy,
  output logic                    o_overrun,
`ifdef PUF_TIE_MASK_EN
  output logic [RESP_BITS-1:0]    o_tie_mask,
`endif
  output puf_state_e              o_state,
  output logic [IDX_W-1:0]        o_pair_idx
);

  puf_state_e              state_q;
  logic [IDX_W-1:0]        pair_idx_q;
  logic [IDX_W-1:0]        pair_idx_d;
  logic [CNT_BIT_SIZE-1:0] a_q;
  logic [RESP_BITS-1:0]    resp_q;
  logic                    resp_valid_q;
  logic                    overrun_q;
  logic                    last_pair;
  logic                    bit_gt;
  logic                    bit_eq;
  logic                    strobe;
`ifdef PUF_TIE_MASK_EN
  logic [RESP_BITS-1:0]    tie_q;
`endif

  // Compare the held first count against the incoming second count.
  puf_pair_cmp #(
    .W (CNT_BIT_SIZE)
  ) u_cmp (
    .a_i  (a_q),
    .b_i  (i_count),
    .gt_o (bit_gt),
    .eq_o (bit_eq)
  );

  // A strobe only counts when the block is enabled.
  assign strobe    = i_valid && i_en;
  assign last_pair = (pair_idx_q == IDX_W'(RESP_BITS - 1));
  // The index saturates on the last pair so it never wraps while holding.
  assign pair_idx_d = last_pair ? pair_idx_q : (pair_idx_q + IDX_W'(1));

  // Main FSM: capture A, capture B and write a bit, hold for the consumer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_CAP_A;
      pair_idx_q   <= '0;
      a_q          <= '0;
      resp_q       <= '0;
      resp_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
`ifdef PUF_TIE_MASK_EN
      tie_q        <= '0;
`endif
    end else begin
      // Any enabled strobe while a word is held (handoff cycle included) is lost.
      if (state_q == S_HOLD && strobe) begin
        overrun_q <= 1'b1;
      end
      case (state_q)
        S_CAP_A: begin
          if (!i_en) begin
            pair_idx_q <= '0;
            a_q        <= '0;
            resp_q     <= '0;
`ifdef PUF_TIE_MASK_EN
            tie_q      <= '0;
`endif
          end else if (i_valid) begin
            a_q     <= i_count;
            state_q <= S_CAP_B;
          end
        end
        S_CAP_B: begin
          if (!i_en) begin
            state_q    <= S_CAP_A;
            pair_idx_q <= '0;
            a_q        <= '0;
            resp_q     <= '0;
`ifdef PUF_TIE_MASK_EN
            tie_q      <= '0;
`endif
          end else if (i_valid) begin
            resp_q[pair_idx_q] <= bit_gt;
`ifdef PUF_TIE_MASK_EN
            tie_q[pair_idx_q]  <= bit_eq;
`endif
            pair_idx_q <= pair_idx_d;
            if (last_pair) begin
              state_q      <= S_HOLD;
              resp_valid_q <= 1'b1;
            end else begin
              state_q <= S_CAP_A;
            end
          end
        end
        S_HOLD: begin
          // Disable does not discard a finished word; only a transfer does.
          if (i_resp_ready) begin
            state_q      <= S_CAP_A;
            pair_idx_q   <= '0;
            a_q          <= '0;
            resp_q       <= '0;
            resp_valid_q <= 1'b0;
`ifdef PUF_TIE_MASK_EN
            tie_q        <= '0;
`endif
          end
        end
        default: begin
          state_q      <= S_CAP_A;
          pair_idx_q   <= '0;
          resp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Tie information is only consumed by the optional mask output.
  logic unused_eq;
`ifdef PUF_TIE_MASK_EN
  assign unused_eq  = 1'b0;
  assign o_tie_mask = tie_q;
`else
  assign unused_eq  = bit_eq;
`endif

  assign o_resp       = resp_q;
  assign o_resp_valid = resp_valid_q;
  assign o_overrun    = overrun_q;
  assign o_busy       = (state_q != S_CAP_A) || (pair_idx_q != '0);
  assign o_state      = state_q;
  assign o_pair_idx   = pair_idx_q;

endmodule

// File: tb/tb_puf_resp_gen.sv
// Directed + randomized bench for puf_resp_gen with RESP_BITS = 4 and
// CNT_BIT_SIZE = 5. Expected words come from a pair-list model: bit k is
// (first count of pair k) > (second count of pair k).
module tb_puf_resp_gen;
  import puf_pkg::*;

  localparam int CW = 5;
  localparam int RB = 4;
  localparam int IW = 2;

  logic          clk;
  logic          rst;
  logic          i_en;
  logic          i_valid;
  logic [CW-1:0] i_count;
  logic          i_resp_ready;
  logic [RB-1:0] o_resp;
  logic          o_resp_valid;
  logic          o_busy;
  logic          o_overrun;
`ifdef PUF_TIE_MASK_EN
  logic [RB-1:0] o_tie_mask;
`endif
  puf_state_e    o_state;
  logic [IW-1:0] o_pair_idx;

  int vectors;
  int miscompares;

  // Pair stimulus for one word and the model's expectations for it.
  logic [CW-1:0] cnt_a [RB];
  logic [CW-1:0] cnt_b [RB];
  logic [RB-1:0] exp_q [$];
  logic [RB-1:0] exp_tie_q [$];
  logic [RB-1:0] exp_word;
  logic [RB-1:0] exp_tie;

  puf_resp_gen #(
    .CNT_BIT_SIZE (CW),
    .RESP_BITS    (RB)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .i_en         (i_en),
    .i_valid      (i_valid),
    .i_count      (i_count),
    .i_resp_ready (i_resp_ready),
    .o_resp       (o_resp),
    .o_resp_valid (o_resp_valid),
    .o_busy       (o_busy),
    .o_overrun    (o_overrun),
`ifdef PUF_TIE_MASK_EN
    .o_tie_mask   (o_tie_mask),
`endif
    .o_state      (o_state),
    .o_pair_idx   (o_pair_idx)
  );

  // Clock and global time limit.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout observed=running required=finished");
    $fatal(1, "time limit reached");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("miscompare on %s", tag);
    end
  endtask

  // Reference model: compute the word and tie mask from the pair list and queue them.
  task automatic model_word();
    logic [RB-1:0] w;
    logic [RB-1:0] t;
    w = '0;
    t = '0;
    for (int k = 0; k < RB; k++) begin
      if (int'(cnt_a[k]) > int'(cnt_b[k])) w = w | RB'(1 << k);
      if (int'(cnt_a[k]) == int'(cnt_b[k])) t = t | RB'(1 << k);
    end
    exp_q.push_back(w);
    exp_tie_q.push_back(t);
  endtask

  task automatic strobe(input logic [CW-1:0] c);
    i_valid = 1'b1;
    i_count = c;
    step();
    i_valid = 1'b0;
    i_count = CW'($urandom_range(0, 31));
  endtask

  // Send the pair list with 'gap' idle cycles between strobes; returns right
  // after the edge that takes the last strobe.
  task automatic run_pairs(input int gap);
    for (int i = 0; i < 2 * RB; i++) begin
      strobe((i % 2 == 0) ? cnt_a[i / 2] : cnt_b[i / 2]);
      if (i == 2 * RB - 2) check("valid_before_last", 32'(o_resp_valid), 32'd0);
      if (i < 2 * RB - 1) repeat (gap) step();
    end
  endtask

  task automatic check_word(input string tag);
    exp_word = exp_q.pop_front();
    exp_tie  = exp_tie_q.pop_front();
    check({tag, "_valid"}, 32'(o_resp_valid), 32'd1);
    check({tag, "_resp"}, 32'(o_resp), 32'(exp_word));
`ifdef PUF_TIE_MASK_EN
    check({tag, "_tie"}, 32'(o_tie_mask), 32'(exp_tie));
`endif
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_valid"}, 32'(o_resp_valid), 32'd0);
    check({tag, "_resp"}, 32'(o_resp), 32'd0);
    check({tag, "_state"}, 32'(o_state), 32'(S_CAP_A));
    check({tag, "_idx"}, 32'(o_pair_idx), 32'd0);
`ifdef PUF_TIE_MASK_EN
    check({tag, "_tie"}, 32'(o_tie_mask), 32'd0);
`endif
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic random_pairs();
    for (int k = 0; k < RB; k++) begin
      cnt_a[k] = CW'($urandom_range(0, 31));
      cnt_b[k] = ($urandom_range(0, 3) == 0) ? cnt_a[k] : CW'($urandom_range(0, 31));
    end
  endtask

  // Directed scenarios followed by randomized words.
  initial begin
    vectors      = 0;
    miscompares  = 0;
    rst          = 1'b1;
    i_en         = 1'b1;
    i_valid      = 1'b0;
    i_count      = '0;
    i_resp_ready = 1'b0;
    do_reset();

    // Reset state.
    check_cleared("reset");
    check("reset_busy", 32'(o_busy), 32'd0);
    check("reset_overrun", 32'(o_overrun), 32'd0);

    // Mixed pairs, consumer not ready: word held and stable.
    cnt_a[0] = 5'd20; cnt_b[0] = 5'd10;
    cnt_a[1] = 5'd3;  cnt_b[1] = 5'd17;
    cnt_a[2] = 5'd31; cnt_b[2] = 5'd30;
    cnt_a[3] = 5'd0;  cnt_b[3] = 5'd1;
    model_word();
    check("s1_model", 32'(exp_q[0]), 32'h5);
    run_pairs(0);
    check_word("s1");
    check("s1_busy", 32'(o_busy), 32'd1);
    repeat (3) step();
    check("s1_hold_valid", 32'(o_resp_valid), 32'd1);
    check("s1_hold_resp", 32'(o_resp), 32'(exp_word));
    i_resp_ready = 1'b1;
    step();
    i_resp_ready = 1'b0;
    check_cleared("s1_xfer");

    // Tie on pair 0, then three clear wins; overrun during hold and handoff.
    cnt_a[0] = 5'd9; cnt_b[0] = 5'd9;
    for (int k = 1; k < RB; k++) begin
      cnt_a[k] = 5'd5;
      cnt_b[k] = 5'd2;
    end
    model_word();
    run_pairs(1);
    check_word("s2");
    i_valid = 1'b1;
    step();
    check("s2_ovr_hold", 32'(o_overrun), 32'd1);
    check("s2_ovr_valid", 32'(o_resp_valid), 32'd1);
    check("s2_ovr_resp", 32'(o_resp), 32'(exp_word));
    i_resp_ready = 1'b1;
    step();
    i_valid      = 1'b0;
    i_resp_ready = 1'b0;
    check_cleared("s2_xfer");
    check("s2_ovr_sticky", 32'(o_overrun), 32'd1);
    repeat (2) step();
    check("s2_ovr_sticky2", 32'(o_overrun), 32'd1);

    // Disable mid-word discards partial data; a strobe while disabled is ignored.
    do_reset();
    random_pairs();
    strobe(cnt_a[0]);
    strobe(cnt_b[0]);
    strobe(cnt_a[1]);
    check("s3_idx_mid", 32'(o_pair_idx), 32'd1);
    check("s3_state_mid", 32'(o_state), 32'(S_CAP_B));
    check("s3_busy_mid", 32'(o_busy), 32'd1);
    i_en    = 1'b0;
    i_valid = 1'b1;
    step();
    i_valid = 1'b0;
    i_en    = 1'b1;
    check_cleared("s3_abort");
    check("s3_busy", 32'(o_busy), 32'd0);
    check("s3_overrun", 32'(o_overrun), 32'd0);
    random_pairs();
    model_word();
    run_pairs(0);
    check_word("s3");
    // Disable while holding keeps the word.
    i_en = 1'b0;
    step();
    step();
    i_en = 1'b1;
    check("s3_hold_en_valid", 32'(o_resp_valid), 32'd1);
    check("s3_hold_en_resp", 32'(o_resp), 32'(exp_word));

    // Reset while holding a word.
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_cleared("s4_rst");
    check("s4_busy", 32'(o_busy), 32'd0);
    check("s4_overrun", 32'(o_overrun), 32'd0);

    // Back-to-back words, consumer always ready, one idle cycle between strobes.
    i_resp_ready = 1'b1;
    for (int w = 0; w < 2; w++) begin
      random_pairs();
      model_word();
      run_pairs(1);
      check_word("s5");
      step();
      check("s5_drained", 32'(o_resp_valid), 32'd0);
    end
    i_resp_ready = 1'b0;
    check("s5_overrun", 32'(o_overrun), 32'd0);

    // Randomized words with random gaps and hold times.
    for (int w = 0; w < 8; w++) begin
      random_pairs();
      model_word();
      run_pairs($urandom_range(0, 2));
      check_word("rnd");
      repeat ($urandom_range(0, 3)) step();
      check("rnd_hold_resp", 32'(o_resp), 32'(exp_word));
      i_resp_ready = 1'b1;
      step();
      i_resp_ready = 1'b0;
      check_cleared("rnd_xfer");
    end
    check("rnd_overrun", 32'(o_overrun), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
